seg7_capture: RTL and testbench

Sequential receiver for multiplexed seven-segment display buses. It samples the segment lines and one-hot digit selects of a `DIGITS`-wide display and waits until each digit's pattern has been stable long enough. Each stable pattern is converted back to BCD, and a full frame is presented on a valid/ready output. It is the receive end of the BCD→seven-segment path: captured display traffic can be checked against the BCD that produced it.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg7_capture.sv | 129 ++++++++++++
 tb/tb_seg7_capture.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Segment ordering everywhere is {a,b,c,d,e,f,g} with a in bit 6.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic {
      COLLECT,
      PRESENT
   } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the BCD-to-seven-segment encoder.
// Anything outside the ten legal digit codes maps to BCD_INVALID with err set.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_INVALID;
      err = 1'b1;
      case (seg)
         SEG_0: begin bcd = 4'd0; err = 1'b0; end
         SEG_1: begin bcd = 4'd1; err = 1'b0; end
         SEG_2: begin bcd = 4'd2; err = 1'b0; end
         SEG_3: begin bcd = 4'd3; err = 1'b0; end
         SEG_4: begin bcd = 4'd4; err = 1'b0; end
         SEG_5: begin bcd = 4'd5; err = 1'b0; end
         SEG_6: begin bcd = 4'd6; err = 1'b0; end
         SEG_7: begin bcd = 4'd7; err = 1'b0; end
         SEG_8: begin bcd = 4'd8; err = 1'b0; end
         SEG_9: begin bcd = 4'd9; err = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Receiver for a multiplexed seven-segment bus: debounces each digit's pattern,
// decodes it back to BCD and hands complete frames out on a valid/ready port.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     err_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CAP_AT  = CW'(STABLE_CYCLES - 1);

   logic [6:0]                  s_seg_q, s_seg_d, p_seg_q;
   logic [DIGITS-1:0]           s_sel_q, s_sel_d, p_sel_q;
   logic [CW-1:0]               cnt_q, cnt_d;
   state_t                      state_q, state_d;
   logic [DIGITS-1:0][3:0]      slot_q, slot_d;
   logic [DIGITS-1:0]           err_q, err_d;
   logic [DIGITS-1:0]           captured_q, captured_d;
   logic                        out_valid_q, out_valid_d;
   logic                        overrun_q, overrun_d;

   logic       one_hot, changed, clr, cap;
   logic [3:0] dec_bcd;
   logic       dec_err;

   seg7_to_bcd u_dec (
      .seg (s_seg_q),
      .bcd (dec_bcd),
      .err (dec_err)
   );

   // Stability tracking: p_* holds the previous cycle's registered sample.
   always_comb begin
      s_seg_d = seg_in;
      s_sel_d = dig_sel;
      one_hot = $onehot(s_sel_q);
      changed = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);
      clr     = changed || !one_hot;
      if (clr)
         cnt_d = '0;
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 1'b1;
      // The clr term lets STABLE_CYCLES==1 fire on the first sample of an interval.
      cap = one_hot && (cnt_d == CAP_AT) && (clr || (cnt_q != CAP_AT));
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      err_d       = err_q;
      captured_d  = captured_q;
      out_valid_d = out_valid_q;
      overrun_d   = 1'b0;
      case (state_q)
         COLLECT: begin
            if (cap) begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (s_sel_q[i]) begin
                     slot_d[i] = dec_bcd;
                     err_d[i]  = dec_err;
                  end
               end
               captured_d = captured_q | s_sel_q;
               if (&captured_d) begin
                  state_d     = PRESENT;
                  out_valid_d = 1'b1;
               end
            end
         end
         PRESENT: begin
            overrun_d = cap;
            if (out_ready) begin
               state_d     = COLLECT;
               captured_d  = '0;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_seg_q     <= '0;
         s_sel_q     <= '0;
         p_seg_q     <= '0;
         p_sel_q     <= '0;
         cnt_q       <= '0;
         state_q     <= COLLECT;
         slot_q      <= '0;
         err_q       <= '0;
         captured_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         s_seg_q     <= s_seg_d;
         s_sel_q     <= s_sel_d;
         p_seg_q     <= s_seg_q;
         p_sel_q     <= s_sel_q;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         slot_q      <= slot_d;
         err_q       <= err_d;
         captured_q  <= captured_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bcd_out   = slot_q;
   assign err_out   = err_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized and directed bench for seg7_capture against a run-length /
// frame-set reference model of the capture rules.
module tb_seg7_capture;

   localparam int D  = 4;
   localparam int ST = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [6:0]     seg_in = '0;
   logic [D-1:0]   dig_sel = '0;
   logic           out_ready = 1'b1;
   logic [4*D-1:0] bcd_out;
   logic [D-1:0]   err_out;
   logic           out_valid;
   logic           overrun;

   always #5 clk = ~clk;

   seg7_capture #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_in    (seg_in),
      .dig_sel   (dig_sel),
      .bcd_out   (bcd_out),
      .err_out   (err_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   int n_tests = 0;
   int n_fail  = 0;
   int ovr_seen = 0;

   // reference model state
   logic [6:0]     m_last_seg = '0;
   logic [D-1:0]   m_last_sel = '0;
   int             m_run = 1;
   logic [4*D-1:0] m_bcd = '0;
   logic [D-1:0]   m_err = '0;
   logic [D-1:0]   m_capd = '0;
   logic           m_present = 1'b0;
   logic           m_ovr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] ref_dec(input logic [6:0] s);
      for (int k = 0; k < 10; k++)
         if (codes[k] == s) return {1'b0, 4'(k)};
      return {1'b1, 4'hF};
   endfunction

   // A digit is captured on the edge after its registered sample has repeated ST times.
   task automatic model_edge();
      logic       cap;
      logic [4:0] d;
      if (!rst_n) begin
         m_last_seg = '0; m_last_sel = '0; m_run = 1;
         m_bcd = '0; m_err = '0; m_capd = '0; m_present = 1'b0; m_ovr = 1'b0;
         return;
      end
      cap   = ($countones(m_last_sel) == 1) && (m_run == ST);
      m_ovr = 1'b0;
      if (m_present) begin
         if (cap) m_ovr = 1'b1;
         if (out_ready) begin
            m_present = 1'b0;
            m_capd    = '0;
         end
      end else if (cap) begin
         d = ref_dec(m_last_seg);
         for (int i = 0; i < D; i++) begin
            if (m_last_sel[i]) begin
               m_bcd[4*i +: 4] = d[3:0];
               m_err[i]        = d[4];
            end
         end
         m_capd = m_capd | m_last_sel;
         if (&m_capd) m_present = 1'b1;
      end
      if (seg_in == m_last_seg && dig_sel == m_last_sel) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run      = 1;
         m_last_seg = seg_in;
         m_last_sel = dig_sel;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("bcd",   32'(bcd_out),   32'(m_bcd));
      chk("err",   32'(err_out),   32'(m_err));
      chk("valid", 32'(out_valid), 32'(m_present));
      chk("ovr",   32'(overrun),   32'(m_ovr));
      ovr_seen += int'(overrun);
   endtask

   task automatic hold(input logic [6:0] s, input logic [D-1:0] sel, input int n);
      seg_in  = s;
      dig_sel = sel;
      repeat (n) cyc();
   endtask

   initial begin
      int ovr0;
      rst_n = 1'b0;
      out_ready = 1'b1;
      repeat (2) cyc();
      chk("rst_bcd", 32'(bcd_out), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;

      // basic frame 0843
      hold(7'b1111001, 4'b0001, 3);
      hold(7'b0110011, 4'b0010, 3);
      hold(7'b1111111, 4'b0100, 3);
      hold(7'b1111110, 4'b1000, 3);
      hold(7'b0000000, 4'b0000, 1);
      chk("frame_valid", 32'(out_valid), 32'h1);
      chk("frame_bcd", 32'(bcd_out), 32'h0843);
      chk("frame_err", 32'(err_out), 32'h0);
      hold(7'b0000000, 4'b0000, 2);
      chk("frame_taken", 32'(out_valid), 32'h0);

      // illegal digit 0 plus a glitch on digit 1
      hold(7'b0001000, 4'b0001, 3);
      hold(7'b0110000, 4'b0010, 2);
      hold(7'b1101101, 4'b0010, 3);
      hold(7'b1011011, 4'b0100, 3);
      hold(7'b1110000, 4'b1000, 3);
      hold(7'b0000000, 4'b0000, 1);
      chk("ill_bcd", 32'(bcd_out), 32'h752F);
      chk("ill_err", 32'(err_out), 32'h1);

      // backpressure: frame frozen, each stable interval dropped with overrun
      out_ready = 1'b0;
      ovr0 = ovr_seen;
      for (int j = 0; j < 7; j++) hold(codes[j], 4'(1 << (j % 4)), 3);
      chk("frozen_bcd", 32'(bcd_out), 32'h752F);
      chk("held_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      hold(7'b0000000, 4'b0000, 1);
      chk("ovr_count", 32'(ovr_seen - ovr0), 32'd7);
      chk("bp_taken", 32'(out_valid), 32'h0);
      hold(codes[9], 4'b0001, 3);
      hold(7'b0000000, 4'b0000, 2);
      chk("empty_start", 32'(out_valid), 32'h0);

      // non-one-hot selects never capture
      ovr0 = ovr_seen;
      hold(codes[8], 4'b0011, 10);
      hold(codes[8], 4'b0000, 10);
      chk("nonhot_ovr", 32'(ovr_seen - ovr0), 32'd0);

      // reset with three digits captured
      hold(codes[1], 4'b0001, 3);
      hold(codes[2], 4'b0010, 3);
      hold(codes[3], 4'b0100, 3);
      hold(7'b0000000, 4'b0000, 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
      chk("mid_rst_err", 32'(err_out), 32'h0);
      hold(codes[4], 4'b1000, 3);
      hold(7'b0000000, 4'b0000, 2);
      chk("post_rst_nofrm", 32'(out_valid), 32'h0);

      // randomized scanning
      for (int it = 0; it < 300; it++) begin
         logic [6:0]   s;
         logic [D-1:0] sel;
         if ($urandom_range(59) == 0) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end
         out_ready = ($urandom_range(3) != 0);
         sel = ($urandom_range(7) == 0) ? D'($urandom) : D'(1 << $urandom_range(D - 1));
         s   = ($urandom_range(5) == 0) ? 7'($urandom) : codes[$urandom_range(9)];
         hold(s, sel, int'($urandom_range(5, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
